// File: rtl/noc_traffic_client_if.sv
// Load and injection handshake bundle for the NoC traffic client.
// Latency: none, signal bundle only.
// Backpressure: ld_rdy throttles loads, i_ack releases the held injection slot.
interface noc_traffic_client_if #(
    parameter int VC_W = 1,
    parameter int X_W  = 2,
    parameter int Y_W  = 2,
    parameter int D_W  = 28
);
    logic            ld_v;
    logic            ld_rdy;
    logic [VC_W-1:0] ld_vc;
    logic [X_W-1:0]  ld_x;
    logic [Y_W-1:0]  ld_y;
    logic [D_W-1:0]  ld_data;

    logic            i_v;
    logic            i_ack;
    logic [VC_W-1:0] i_vc;
    logic [X_W-1:0]  i_x;
    logic [Y_W-1:0]  i_y;
    logic [D_W-1:0]  i_data;

    // Client side: accepts loads, drives injections
    modport master (
        input  ld_v, ld_vc, ld_x, ld_y, ld_data, i_ack,
        output ld_rdy, i_v, i_vc, i_x, i_y, i_data
    );

    // Environment side: issues loads, acknowledges injections
    modport slave (
        output ld_v, ld_vc, ld_x, ld_y, ld_data, i_ack,
        input  ld_rdy, i_v, i_vc, i_x, i_y, i_data
    );
endinterface

// File: rtl/noc_traffic_client.sv
// Multi-VC token-bucket shaped traffic injector with round-robin VC service.
// Latency: load to i_v one edge at the earliest; back-to-back injects with no bubble.
// Backpressure: i_v and fields hold until i_ack; ld_rdy drops when the target queue is full.
module noc_traffic_client #(
    parameter int NUM_VC = 2,
    parameter int VC_W   = 1,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int D_W    = 28,
    parameter int SIGMA  = 3,
    parameter int RATE   = 20,
    parameter int QDEPTH = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_traffic_client_if.master bus,
    input  logic                 regulate,
    input  logic [CNT_W-1:0]     total_pkts,
    input  logic                 o_v,
    output logic [CNT_W-1:0]     sent_cnt,
    output logic [CNT_W-1:0]     recv_cnt,
    output logic                 done,
    output logic                 rx_done
);
    localparam int AW  = $clog2(QDEPTH);
    localparam int PW  = AW + 1;
    localparam int TW  = $clog2(SIGMA + 1);
    localparam int PHW = (RATE > 1) ? $clog2(RATE) : 1;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [D_W-1:0] data;
    } pkt_t;

    pkt_t             mem    [NUM_VC][QDEPTH];
    logic [PW-1:0]    wr_ptr [NUM_VC];
    logic [PW-1:0]    rd_ptr [NUM_VC];
    logic [TW-1:0]    tok    [NUM_VC];
    logic [TW-1:0]    tok_nxt[NUM_VC];
    logic [PHW-1:0]   phase;
    logic [VC_W-1:0]  last_grant;
    logic [CNT_W-1:0] issued_cnt;

    logic [NUM_VC-1:0] q_empty, q_full, elig;
    logic              refill, ld_fire, slot_free, grant_any, grant_fire;
    logic [VC_W-1:0]   grant_vc, cand;
    pkt_t              head_pkt;
    logic [TW:0]       tok_sum;

    assign refill     = (phase == PHW'(RATE - 1));
    assign ld_fire    = bus.ld_v & bus.ld_rdy;
    assign slot_free  = !bus.i_v || bus.i_ack;
    assign grant_fire = slot_free & grant_any;

    // Queue status and per-VC eligibility; the MSB of each pointer disambiguates full from empty
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            q_empty[v] = (wr_ptr[v] == rd_ptr[v]);
            q_full[v]  = (wr_ptr[v][PW-1] != rd_ptr[v][PW-1]) &&
                         (wr_ptr[v][PW-2:0] == rd_ptr[v][PW-2:0]);
            elig[v]    = !q_empty[v] && ((tok[v] != '0) || !regulate) &&
                         (issued_cnt < total_pkts);
        end
    end

    // Load ready follows the addressed queue; an out-of-range VC never matches and stays not-ready
    always_comb begin
        bus.ld_rdy = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (bus.ld_vc == VC_W'(v)) bus.ld_rdy = !q_full[v];
        end
    end

    // Round-robin pick: first eligible VC strictly after last_grant, wrapping
    always_comb begin
        grant_any = 1'b0;
        grant_vc  = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_VC; off++) begin
            cand = VC_W'((int'(last_grant) + off) % NUM_VC);
            if (!grant_any && elig[cand]) begin
                grant_any = 1'b1;
                grant_vc  = cand;
            end
        end
    end

    // Head-of-queue packet of the granted VC
    always_comb begin
        head_pkt = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (grant_vc == VC_W'(v)) head_pkt = mem[v][rd_ptr[v][AW-1:0]];
        end
    end

    // Next token level: add refill, remove a consumed token, clamp at bucket depth
    always_comb begin
        tok_sum = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            tok_sum = {1'b0, tok[v]} + {{TW{1'b0}}, refill}
                    - {{TW{1'b0}}, (grant_fire && regulate && (grant_vc == VC_W'(v)))};
            tok_nxt[v] = (tok_sum > (TW+1)'(SIGMA)) ? TW'(SIGMA) : tok_sum[TW-1:0];
        end
    end

    // Queue storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (ld_fire && (bus.ld_vc == VC_W'(v)))
                mem[v][wr_ptr[v][AW-1:0]] <= '{x: bus.ld_x, y: bus.ld_y, data: bus.ld_data};
        end
    end

    // Pointers, buckets, injection slot, counters and completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                tok[v]    <= TW'(SIGMA);
            end
            phase       <= '0;
            last_grant  <= VC_W'(NUM_VC - 1);
            issued_cnt  <= '0;
            bus.i_v     <= 1'b0;
            bus.i_vc    <= '0;
            bus.i_x     <= '0;
            bus.i_y     <= '0;
            bus.i_data  <= '0;
            sent_cnt    <= '0;
            recv_cnt    <= '0;
            done        <= 1'b0;
            rx_done     <= 1'b0;
        end else begin
            phase <= refill ? '0 : phase + PHW'(1);
            for (int v = 0; v < NUM_VC; v++) begin
                tok[v] <= tok_nxt[v];
                if (ld_fire && (bus.ld_vc == VC_W'(v)))
                    wr_ptr[v] <= wr_ptr[v] + PW'(1);
                if (grant_fire && (grant_vc == VC_W'(v)))
                    rd_ptr[v] <= rd_ptr[v] + PW'(1);
            end
            if (slot_free) begin
                if (grant_any) begin
                    bus.i_v    <= 1'b1;
                    bus.i_vc   <= grant_vc;
                    bus.i_x    <= head_pkt.x;
                    bus.i_y    <= head_pkt.y;
                    bus.i_data <= head_pkt.data;
                    issued_cnt <= issued_cnt + CNT_W'(1);
                    last_grant <= grant_vc;
                end else begin
                    bus.i_v    <= 1'b0;
                end
            end
            if (bus.i_v && bus.i_ack) sent_cnt <= sent_cnt + CNT_W'(1);
            if (o_v && (recv_cnt != '1)) recv_cnt <= recv_cnt + CNT_W'(1);
            if ((total_pkts != '0) && (sent_cnt == total_pkts)) done    <= 1'b1;
            if ((total_pkts != '0) && (recv_cnt == total_pkts)) rx_done <= 1'b1;
        end
    end
endmodule

// File: doc/noc_traffic_client.md
# noc_traffic_client

Multi-VC, rate-regulated traffic injector for the NoC test harness. Packets are loaded into per-VC queues, and each VC is shaped by its own token bucket. Eligible VCs are served round-robin onto a single valid/ack injection port. The block also counts injected and ejected packets and raises completion flags once a programmed packet total is reached, which lets one client drive several VCs with independent shaping.

## Interface
Parameters:
- NUM_VC, 2, number of virtual channels/queues/buckets
- VC_W, 1, VC index width (≥ clog2(NUM_VC))
- X_W, 2, destination X width
- Y_W, 2, destination Y width
- D_W, 28, payload width
- SIGMA, 3, bucket depth (max burst per VC)
- RATE, 20, refill period in cycles (one token per VC per period)
- QDEPTH, 8, per-VC queue depth (power of 2)
- CNT_W, 16, width of packet counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ld_v  in  1  load request
- ld_rdy  out  1  queue[ld_vc] not full (combinational on ld_vc)
- ld_vc  in  VC_W  target queue
- ld_x / ld_y / ld_data  in  X_W / Y_W / D_W  packet fields
- regulate  in  1  1 = token buckets enforced, 0 = unshaped
- total_pkts  in  CNT_W  packets to inject/expect; held stable after reset
- i_v  out  1  injection valid
- i_ack  in  1  router accepted current packet
- i_vc / i_x / i_y / i_data  out  VC_W / X_W / Y_W / D_W  injected packet
- o_v  in  1  ejected packet valid (counted only)
- sent_cnt  out  CNT_W  packets acked
- recv_cnt  out  CNT_W  packets ejected
- done  out  1  sticky: sent_cnt == total_pkts, total_pkts ≠ 0
- rx_done  out  1  sticky: recv_cnt == total_pkts, total_pkts ≠ 0

## Operation
- **Load:**
  - Accept on ld_v & ld_rdy; write to the tail of queue[ld_vc].
  - ld_vc ≥ NUM_VC is ignored (ld_rdy = 0).
  - Write to a full queue: not accepted, no state change.
- **Buckets:**
  - One shared phase counter counts 0..RATE-1; at wrap every bucket gets +1 refill.
  - Per bucket: tok ← min(SIGMA, tok + refill − consume), width clog2(SIGMA+1).
  - Simultaneous refill and consume on a full bucket leaves tok = SIGMA.
- **Eligibility:** VC v is eligible when queue[v] is nonempty, (tok[v] > 0 or !regulate), and issued_cnt < total_pkts.
- **Slot free:** when !i_v, or i_v & i_ack.
- **Grant:**
  - If the slot is free and any VC is eligible, a round-robin arbiter picks the first eligible VC after last_grant (wrapping).
  - On grant: pop that queue, consume its token only if regulate, register the fields into i_*, set i_v, increment issued_cnt, set last_grant.
  - Slot free and no eligible VC: i_v ← 0.
- **Hold:** while i_v & !i_ack, all i_* outputs stay stable and no grant occurs.
- **Ack accounting:**
  - i_ack with i_v increments sent_cnt.
  - i_ack with !i_v is ignored.
- **Eject accounting:** o_v increments recv_cnt, saturating at all-ones.
- **Completion:** done and rx_done are set by their compare and cleared only by rst.

## Timing
- Reset values: i_v = 0, i_vc/i_x/i_y/i_data = 0, sent_cnt = recv_cnt = 0, done = rx_done = 0, queues empty, every tok = SIGMA, phase = 0, last_grant = NUM_VC-1 (so VC0 has first priority).
- Load-to-inject latency: a packet accepted at edge t can drive i_v = 1 after edge t+1 at the earliest.
- Back-to-back injection: ack at edge t with another eligible VC gives new fields and i_v = 1 after edge t, with no bubble.
- Counter and flag timing:
  - sent_cnt updates at the ack edge.
  - done is asserted one edge after sent_cnt reaches total_pkts.
- Regulated throughput: steady state per VC is one packet per RATE cycles, with bursts of up to SIGMA.
- Reset mid-operation: an in-flight packet is dropped (i_v = 0 after the rst edge, even if i_ack is coincident); all queues and counters clear.
- Queue pointers are clog2(QDEPTH)+1 bits wide; full/empty is decided by MSB compare and wraps cleanly past QDEPTH.

## Test plan
- **Burst then refill:** regulate=1, SIGMA=3, RATE=20, 5 pkts on VC0, i_ack tied 1 → pkts 1–3 on consecutive cycles; pkt 4 at the first phase wrap (cycle 20 after reset); pkt 5 at cycle 40.
- **Round-robin:** regulate=0, 3 pkts on each of VC0 and VC1 preloaded, i_ack=1 → i_vc sequence 0,1,0,1,0,1.
- **Ack stall:** i_ack held 0 for 10 cycles → i_v and fields stable all 10 cycles; sent_cnt unchanged; a single ack advances sent_cnt by exactly 1.
- **Queue full:** QDEPTH=8, load 9 to VC1 with no drain → ld_rdy = 0 on the 9th; the 9th is not stored; exactly 8 are later injected.
- **Completion:** total_pkts=4, 6 loaded → exactly 4 injected; done rises after the 4th ack; 4 o_v pulses set rx_done; remaining 2 stay queued.
- **Reset mid-flight:** rst asserted while i_v=1 and i_ack=1 → after the edge i_v=0, sent_cnt=0, tok=SIGMA, ld_rdy=1 for all VCs.
